seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Logic ops and add/sub complete in one cycle. Multiply runs as an iterative shift-add; optional unsigned divide runs as shift-subtract.
- Uses a valid/ready handshake on input and output, so the EX stage can stall on long ops.
- Provides zero, overflow and illegal-op flags, and the full 2*WIDTH product.

---
 rtl/seq_alu_pkg.sv | 25 ++
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_alu_iter_unit.sv | 95 +++++++++
 rtl/seq_alu.sv | 159 +++++++++++++++
 tb/tb_seq_alu.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Package alu_pkg: shared opcode encodings, FSM state type and default
// opcode width for the sequential ALU slice.
// Ports: none (package).
package alu_pkg;

  localparam int CTRL_W_DEF = 4;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_MUL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_DIVU = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle of the sequential ALU.
// master: drives in_valid, operand1, operand2, alu_ctrl, out_ready;
//         observes in_ready, out_valid, res, res_hi and the flags.
// slave : the ALU side (directions reversed).
interface seq_alu_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = alu_pkg::CTRL_W_DEF
) ();
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  operand1;
  logic [WIDTH-1:0]  operand2;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  res_hi;
  logic              flag_zero;
  logic              flag_ovf;
  logic              flag_illegal;

  modport master (
    output in_valid, operand1, operand2, alu_ctrl, out_ready,
    input  in_ready, out_valid, res, res_hi, flag_zero, flag_ovf, flag_illegal
  );

  modport slave (
    input  in_valid, operand1, operand2, alu_ctrl, out_ready,
    output in_ready, out_valid, res, res_hi, flag_zero, flag_ovf, flag_illegal
  );
endinterface

// File: rtl/seq_alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle engine shared by multiply (shift-add)
// and, when SEQ_ALU_DIV_EN is defined, unsigned divide (restoring
// shift-subtract). Runs WIDTH steps after start.
// Ports: clk, rst_n (async active-low), div_mode (only with SEQ_ALU_DIV_EN),
//        start, op_a, op_b in; done (pulse during the last step),
//        out_hi/out_lo = accumulator value produced by the current step.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_ALU_DIV_EN
  input  logic             div_mode,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   b_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
`ifdef SEQ_ALU_DIV_EN
  logic               mode_r;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH-1:0]   rem_new_s;
`endif
  logic [WIDTH-1:0]   acc_hi_s;
  logic [WIDTH-1:0]   acc_lo_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               done_s;

  // One iteration: hi half is the running partial sum / remainder,
  // lo half the multiplier bits still to consume / quotient being built.
  always_comb begin
    acc_hi_s   = acc_r[2*WIDTH-1:WIDTH];
    acc_lo_s   = acc_r[WIDTH-1:0];
    mul_sum_s  = {1'b0, acc_hi_s} + ({1'b0, b_r} & {(WIDTH+1){acc_lo_s[0]}});
    acc_next_s = {mul_sum_s, acc_lo_s[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    rem_sh_s  = {acc_hi_s, acc_lo_s[WIDTH-1]};
    // rem_sh >= b guarantees the difference fits WIDTH bits; b == 0 always
    // subtracts, giving quotient all ones and remainder == dividend.
    rem_new_s = rem_sh_s[WIDTH-1:0] - b_r;
    if (mode_r) begin
      if (rem_sh_s >= {1'b0, b_r}) begin
        acc_next_s = {rem_new_s, acc_lo_s[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {rem_sh_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_lo_s[WIDTH-1:1]};
    end
`endif
    done_s = busy_r & (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Operand load on start, then one step per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= '0;
      b_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      mode_r <= 1'b0;
`endif
    end else if (start) begin
      acc_r  <= {{WIDTH{1'b0}}, op_a};
      b_r    <= op_b;
      cnt_r  <= '0;
      busy_r <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
      mode_r <= div_mode;
`endif
    end else if (busy_r) begin
      acc_r  <= acc_next_s;
      cnt_r  <= cnt_r + CNT_W'(1);
      busy_r <= ~done_s;
    end else begin
      acc_r  <= acc_r;
    end
  end

  assign done   = done_s;
  assign out_hi = acc_next_s[2*WIDTH-1:WIDTH];
  assign out_lo = acc_next_s[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake. Logic ops, ADD, SUB
// and SLT finish in one cycle; MUL (and DIVU when SEQ_ALU_DIV_EN is
// defined) take WIDTH+1 cycles through alu_iter_unit.
// Ports: clk, rst_n (async active-low); bus (seq_alu_if.slave) carrying
//        in_valid/in_ready, operand1/2, alu_ctrl, out_valid/out_ready,
//        res, res_hi, flag_zero, flag_ovf, flag_illegal.
// Macro: SEQ_ALU_DIV_EN enables opcode 1000 (DIVU); otherwise it is illegal.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_alu_if.slave bus
);
  state_t           state_r, state_s;
  logic             in_ready_s, accept_s, start_s;
  logic             is_mul_s, is_div_s, legal_s, ovf_s;
  logic [WIDTH-1:0] a_s, b_s, sum_s, dif_s, simple_res_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_hi_s, iter_lo_s;
  logic [WIDTH-1:0] res_r, res_hi_r;
  logic             zero_r, ovf_r, illegal_r, out_valid_r;

  assign a_s        = bus.operand1;
  assign b_s        = bus.operand2;
  assign sum_s      = a_s + b_s;
  assign dif_s      = a_s - b_s;
  assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign start_s    = accept_s & (is_mul_s | is_div_s);

  // Opcode decode and single-cycle results.
  always_comb begin
    simple_res_s = '0;
    ovf_s        = 1'b0;
    legal_s      = 1'b1;
    is_mul_s     = 1'b0;
    is_div_s     = 1'b0;
    case (bus.alu_ctrl)
      CTRL_W'(ALU_AND): simple_res_s = a_s & b_s;
      CTRL_W'(ALU_OR):  simple_res_s = a_s | b_s;
      CTRL_W'(ALU_ADD): begin
        simple_res_s = sum_s;
        ovf_s = (a_s[WIDTH-1] == b_s[WIDTH-1]) & (sum_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      CTRL_W'(ALU_SUB): begin
        simple_res_s = dif_s;
        ovf_s = (a_s[WIDTH-1] != b_s[WIDTH-1]) & (dif_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      CTRL_W'(ALU_MUL): is_mul_s = 1'b1;
      CTRL_W'(ALU_SLT): simple_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
      CTRL_W'(ALU_XOR): simple_res_s = a_s ^ b_s;
      CTRL_W'(ALU_NOR): simple_res_s = ~(a_s | b_s);
`ifdef SEQ_ALU_DIV_EN
      CTRL_W'(ALU_DIVU): is_div_s = 1'b1;
`endif
      default: legal_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE can accept a new op in the cycle it is drained.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_s = MUL_RUN;
          end else if (is_div_s) begin
            state_s = DIV_RUN;
          end else begin
            state_s = DONE;
          end
        end else if (state_r == DONE && bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      MUL_RUN, DIV_RUN: begin
`else
      MUL_RUN: begin
`endif
        if (iter_done_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Result/flag registers: loaded at accept for 1-cycle ops, at the final
  // iteration for MUL/DIVU, held otherwise (stable while stalled in DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r       <= '0;
      res_hi_r    <= '0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_s == DONE);
      if (accept_s && !is_mul_s && !is_div_s) begin
        res_r     <= simple_res_s;
        res_hi_r  <= '0;
        zero_r    <= (simple_res_s == '0);
        ovf_r     <= ovf_s;
        illegal_r <= ~legal_s;
      end else if (iter_done_s) begin
        res_r     <= iter_lo_s;
        res_hi_r  <= iter_hi_s;
        zero_r    <= (iter_lo_s == '0);
        ovf_r     <= 1'b0;
        illegal_r <= 1'b0;
      end else begin
        res_r     <= res_r;
      end
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SEQ_ALU_DIV_EN
    .div_mode (is_div_s),
`endif
    .start    (start_s),
    .op_a     (a_s),
    .op_b     (b_s),
    .done     (iter_done_s),
    .out_hi   (iter_hi_s),
    .out_lo   (iter_lo_s)
  );

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.res          = res_r;
  assign bus.res_hi       = res_hi_r;
  assign bus.flag_zero    = zero_r;
  assign bus.flag_ovf     = ovf_r;
  assign bus.flag_illegal = illegal_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed steps followed by
// randomized ops compared with an arithmetic reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_alu_if #(.WIDTH(32), .CTRL_W(4)) bus ();

  seq_alu #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        il;
    logic [7:0]  lat;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    logic [63:0] p;
    e = '0;
    e.lat = 8'd1;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        e.res = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.o = (s != longint'($signed(e.res)));
      end
      4'd3: begin
        e.res = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.o = (s != longint'($signed(e.res)));
      end
      4'd4: begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.hi = p[63:32];
        e.lat = 8'd33;
      end
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: e.res = a ^ b;
      4'd7: e.res = ~(a | b);
`ifdef SEQ_ALU_DIV_EN
      4'd8: begin
        e.res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        e.hi  = (b == 32'd0) ? a : a % b;
        e.lat = 8'd33;
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, count latency, compare, optional output stall.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string tag);
    exp_t e;
    int cnt;
    e = model(op, a, b);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = op;
    bus.operand1  = a;
    bus.operand2  = b;
    @(negedge clk);
    check({tag, " in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.operand1 = $urandom();
    bus.operand2 = $urandom();
    bus.alu_ctrl = 4'($urandom_range(0, 15));
    cnt = 1;
    while (!bus.out_valid && cnt < 100) begin
      check({tag, " in_ready_busy"}, 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'(e.lat));
    check({tag, " res"}, 64'(bus.res), 64'(e.res));
    check({tag, " res_hi"}, 64'(bus.res_hi), 64'(e.hi));
    check({tag, " flags"}, 64'({bus.flag_zero, bus.flag_ovf, bus.flag_illegal}),
          64'({e.z, e.o, e.il}));
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
        check({tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, " hold_res"}, {bus.res_hi, bus.res}, {e.hi, e.res});
        check({tag, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check({tag, " in_ready_drain"}, 64'(bus.in_ready), 64'd1);
    end
    @(posedge clk); #1;
    check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operand1  = 32'd0;
    bus.operand2  = 32'd0;
    bus.alu_ctrl  = 4'd0;

    // Reset state (checked while rst_n is still low).
    #12;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset res", {bus.res_hi, bus.res}, 64'd0);
    check("reset flags", 64'({bus.flag_zero, bus.flag_ovf, bus.flag_illegal}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed overflow boundary.
    run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf");
    check("add_ovf literal", 64'(model(4'd2, 32'h7FFF_FFFF, 32'd1).res), 64'h8000_0000);

    // SUB 5-5 then AND accepted in the DONE cycle.
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'd3; bus.operand1 = 32'd5; bus.operand2 = 32'd5;
    @(posedge clk); #1;
    check("b2b sub valid", 64'(bus.out_valid), 64'd1);
    check("b2b sub res", 64'(bus.res), 64'd0);
    check("b2b sub zero", 64'(bus.flag_zero), 64'd1);
    check("b2b in_ready", 64'(bus.in_ready), 64'd1);
    bus.alu_ctrl = 4'd0; bus.operand1 = 32'hF0F0_1234; bus.operand2 = 32'h0FF0_FF00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b and valid", 64'(bus.out_valid), 64'd1);
    check("b2b and res", 64'(bus.res), 64'h0000_0000_00F0_1200);
    @(posedge clk); #1;
    check("b2b drained", 64'(bus.out_valid), 64'd0);

    // Multiply corner and output stall.
    run_op(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
    run_op(4'd4, 32'h1234_5678, 32'h9ABC_DEF0, 5, "mul_stall");

    // Reset in the middle of a multiply.
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'd4; bus.operand1 = 32'd77; bus.operand2 = 32'd99;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid no result", 64'(bus.out_valid), 64'd0);
    run_op(4'd2, 32'd2, 32'd3, 0, "add_after_rst");

    // Divide (or illegal without the divide option) and a plain illegal opcode.
    run_op(4'd8, 32'd100, 32'd7, 0, "divu");
    run_op(4'd8, 32'd100, 32'd0, 1, "divu_zero");
    run_op(4'hF, 32'd123, 32'd456, 0, "illegal");

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 8));
      run_op(op, rnd_operand(), rnd_operand(), $urandom_range(0, 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
